// File: rtl/sipo_frame_ctrl.sv
// Serial-in/parallel-out framing controller with valid/ready output and overrun detect.
// Optional trailing even-parity bit check: define SIPO_FRAME_PARITY_EN.
module sipo_frame_ctrl #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_start,
    input  logic         i_ser_in,
    input  logic         i_ser_valid,
    output logic [W-1:0] o_out_data,
    output logic         o_out_valid,
    input  logic         i_out_ready,
    output logic         o_busy,
    output logic         o_overrun,
    input  logic         i_clr_ovr,
    output logic         o_parity_err
);

    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;

    state_t         r_state, w_next;
    logic [W-1:0]   r_shift, w_shift;
    logic [CW-1:0]  r_cnt, w_cnt;
    logic [W-1:0]   r_data;
    logic           r_valid;
    logic           r_ovr;
    logic           w_done;
    logic [W-1:0]   w_word;
    logic           w_load;
    logic           w_ovr_set;
`ifdef SIPO_FRAME_PARITY_EN
    logic           r_perr;
    logic           w_perr_set;
`endif

    always_comb begin
        w_next  = r_state;
        w_shift = r_shift;
        w_cnt   = r_cnt;
        w_done  = 1'b0;
        w_word  = r_shift;
`ifdef SIPO_FRAME_PARITY_EN
        w_perr_set = 1'b0;
`endif
        unique case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_next = SHIFT;
                    w_cnt  = '0;
                end
            end
            SHIFT: begin
                // A start here restarts the frame; the bit in that cycle is dropped
                if (i_start) begin
                    w_cnt = '0;
                end else if (i_ser_valid) begin
                    w_shift = {r_shift[W-2:0], i_ser_in};
                    w_cnt   = r_cnt + CW'(1);
                    if (r_cnt == CW'(W - 1)) begin
`ifdef SIPO_FRAME_PARITY_EN
                        w_next = PARITY;
`else
                        w_next = IDLE;
                        w_done = 1'b1;
                        w_word = w_shift;
`endif
                    end
                end
            end
`ifdef SIPO_FRAME_PARITY_EN
            PARITY: begin
                if (i_start) begin
                    w_next = SHIFT;
                    w_cnt  = '0;
                end else if (i_ser_valid) begin
                    w_next     = IDLE;
                    w_done     = 1'b1;
                    w_word     = r_shift;
                    w_perr_set = ^{r_shift, i_ser_in};
                end
            end
`endif
            default: w_next = IDLE;
        endcase
    end

    // Output register accepts a word if empty or being drained this edge
    assign w_load    = w_done & (~r_valid | i_out_ready);
    assign w_ovr_set = w_done & r_valid & ~i_out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_cnt   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_shift <= w_shift;
            r_cnt   <= w_cnt;
            if (w_load) begin
                r_data <= w_word;
            end
            r_valid <= w_load | (r_valid & ~i_out_ready);
            r_ovr   <= w_ovr_set | (r_ovr & ~i_clr_ovr);
        end
    end

`ifdef SIPO_FRAME_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perr <= 1'b0;
        end else begin
            r_perr <= w_perr_set | (r_perr & ~i_clr_ovr);
        end
    end
    assign o_parity_err = r_perr;
`else
    assign o_parity_err = 1'b0;
`endif

    assign o_out_data  = r_data;
    assign o_out_valid = r_valid;
    assign o_busy      = (r_state != IDLE);
    assign o_overrun   = r_ovr;

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Directed self-checking bench for sipo_frame_ctrl (W=4).
// Honours SIPO_FRAME_PARITY_EN the same way as the design.
module tb_sipo_frame_ctrl;

    logic       clk;
    logic       rst;
    logic       i_start;
    logic       i_ser_in;
    logic       i_ser_valid;
    logic [3:0] o_out_data;
    logic       o_out_valid;
    logic       i_out_ready;
    logic       o_busy;
    logic       o_overrun;
    logic       i_clr_ovr;
    logic       o_parity_err;

    int total;
    int bad;

    sipo_frame_ctrl #(.W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_start      (i_start),
        .i_ser_in     (i_ser_in),
        .i_ser_valid  (i_ser_valid),
        .o_out_data   (o_out_data),
        .o_out_valid  (o_out_valid),
        .i_out_ready  (i_out_ready),
        .o_busy       (o_busy),
        .o_overrun    (o_overrun),
        .i_clr_ovr    (i_clr_ovr),
        .o_parity_err (o_parity_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    // Sends 4 data bits MSB first (plus even parity bit when enabled);
    // out_ready takes rdy_last just before the completing edge.
    task automatic send_word(input logic [3:0] w, input logic rdy_last);
        for (int i = 3; i >= 0; i--) begin
`ifndef SIPO_FRAME_PARITY_EN
            if (i == 0) i_out_ready = rdy_last;
`endif
            i_ser_valid = 1'b1;
            i_ser_in    = w[i];
            tick();
        end
`ifdef SIPO_FRAME_PARITY_EN
        i_out_ready = rdy_last;
        i_ser_valid = 1'b1;
        i_ser_in    = ^w;
        tick();
`endif
        i_ser_valid = 1'b0;
        i_ser_in    = 1'b0;
    endtask

    task automatic test_reset();
        total++;
        if ({o_out_data, o_out_valid, o_busy, o_overrun, o_parity_err} !== 8'h00) begin
            bad++;
            $display("FAIL reset outs got=%b exp=%b",
                     {o_out_data, o_out_valid, o_busy, o_overrun, o_parity_err}, 8'h00);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        i_out_ready = 1'b1;
        start_frame();
        total++;
        if (o_busy !== 1'b1) begin
            bad++;
            $display("FAIL basic busy got=%b exp=1", o_busy);
        end
        send_word(4'b1011, 1'b1);
        total++;
        if ({o_out_valid, o_out_data, o_busy} !== {1'b1, 4'b1011, 1'b0}) begin
            bad++;
            $display("FAIL basic word v/d/busy got=%b exp=%b",
                     {o_out_valid, o_out_data, o_busy}, {1'b1, 4'b1011, 1'b0});
        end
        tick();
        total++;
        if (o_out_valid !== 1'b0) begin
            bad++;
            $display("FAIL basic valid_pulse got=%b exp=0", o_out_valid);
        end
    endtask

    task automatic test_gapped();
        logic [3:0] w;
        w = 4'b0110;
        i_out_ready = 1'b1;
        start_frame();
        for (int i = 3; i >= 0; i--) begin
            i_ser_valid = 1'b1;
            i_ser_in    = w[i];
            tick();
            i_ser_valid = 1'b0;
            i_ser_in    = 1'b1;
            if (i != 0) begin
                repeat (3) tick();
            end
        end
`ifdef SIPO_FRAME_PARITY_EN
        total++;
        if (o_busy !== 1'b1) begin
            bad++;
            $display("FAIL gapped busy got=%b exp=1", o_busy);
        end
        i_ser_valid = 1'b1;
        i_ser_in    = 1'b0;
        tick();
        i_ser_valid = 1'b0;
`endif
        total++;
        if ({o_out_valid, o_out_data} !== {1'b1, 4'b0110}) begin
            bad++;
            $display("FAIL gapped word got=%b exp=%b",
                     {o_out_valid, o_out_data}, {1'b1, 4'b0110});
        end
        tick();
    endtask

    task automatic test_overrun();
        i_out_ready = 1'b0;
        start_frame();
        send_word(4'b1100, 1'b0);
        total++;
        if ({o_out_valid, o_out_data, o_overrun} !== {1'b1, 4'b1100, 1'b0}) begin
            bad++;
            $display("FAIL ovr first got=%b exp=%b",
                     {o_out_valid, o_out_data, o_overrun}, {1'b1, 4'b1100, 1'b0});
        end
        start_frame();
        send_word(4'b0011, 1'b0);
        total++;
        if ({o_out_valid, o_out_data, o_overrun} !== {1'b1, 4'b1100, 1'b1}) begin
            bad++;
            $display("FAIL ovr drop got=%b exp=%b",
                     {o_out_valid, o_out_data, o_overrun}, {1'b1, 4'b1100, 1'b1});
        end
        i_out_ready = 1'b1;
        tick();
        total++;
        if ({o_out_valid, o_overrun} !== 2'b01) begin
            bad++;
            $display("FAIL ovr accept got=%b exp=01", {o_out_valid, o_overrun});
        end
        i_clr_ovr = 1'b1;
        tick();
        i_clr_ovr = 1'b0;
        total++;
        if (o_overrun !== 1'b0) begin
            bad++;
            $display("FAIL ovr clear got=%b exp=0", o_overrun);
        end
    endtask

    task automatic test_back_to_back();
        i_out_ready = 1'b0;
        start_frame();
        send_word(4'b1010, 1'b0);
        total++;
        if ({o_out_valid, o_out_data} !== {1'b1, 4'b1010}) begin
            bad++;
            $display("FAIL b2b first got=%b exp=%b",
                     {o_out_valid, o_out_data}, {1'b1, 4'b1010});
        end
        start_frame();
        send_word(4'b0101, 1'b1);
        total++;
        if ({o_out_valid, o_out_data, o_overrun} !== {1'b1, 4'b0101, 1'b0}) begin
            bad++;
            $display("FAIL b2b swap got=%b exp=%b",
                     {o_out_valid, o_out_data, o_overrun}, {1'b1, 4'b0101, 1'b0});
        end
        tick();
        total++;
        if (o_out_valid !== 1'b0) begin
            bad++;
            $display("FAIL b2b drain got=%b exp=0", o_out_valid);
        end
    endtask

    task automatic test_restart();
        i_out_ready = 1'b1;
        start_frame();
        i_ser_valid = 1'b1;
        i_ser_in    = 1'b1;
        tick();
        tick();
        i_start = 1'b1;
        tick();
        i_start     = 1'b0;
        i_ser_valid = 1'b0;
        total++;
        if ({o_busy, o_out_valid} !== 2'b10) begin
            bad++;
            $display("FAIL restart busy got=%b exp=10", {o_busy, o_out_valid});
        end
        send_word(4'b0001, 1'b1);
        total++;
        if ({o_out_valid, o_out_data, o_overrun} !== {1'b1, 4'b0001, 1'b0}) begin
            bad++;
            $display("FAIL restart word got=%b exp=%b",
                     {o_out_valid, o_out_data, o_overrun}, {1'b1, 4'b0001, 1'b0});
        end
        tick();
    endtask

    task automatic test_reset_mid();
        i_out_ready = 1'b0;
        start_frame();
        send_word(4'b1111, 1'b0);
        start_frame();
        i_ser_valid = 1'b1;
        i_ser_in    = 1'b1;
        tick();
        tick();
        i_ser_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        total++;
        if ({o_out_data, o_out_valid, o_busy, o_overrun, o_parity_err} !== 8'h00) begin
            bad++;
            $display("FAIL rst_mid outs got=%b exp=%b",
                     {o_out_data, o_out_valid, o_busy, o_overrun, o_parity_err}, 8'h00);
        end
        @(negedge clk);
        rst = 1'b0;
        i_out_ready = 1'b1;
        start_frame();
        send_word(4'b1011, 1'b1);
        total++;
        if ({o_out_valid, o_out_data} !== {1'b1, 4'b1011}) begin
            bad++;
            $display("FAIL rst_mid after got=%b exp=%b",
                     {o_out_valid, o_out_data}, {1'b1, 4'b1011});
        end
        tick();
    endtask

    task automatic test_parity();
`ifdef SIPO_FRAME_PARITY_EN
        logic [4:0] v;
        i_out_ready = 1'b1;
        v = 5'b10111;
        start_frame();
        for (int i = 4; i >= 0; i--) begin
            i_ser_valid = 1'b1;
            i_ser_in    = v[i];
            tick();
        end
        i_ser_valid = 1'b0;
        total++;
        if ({o_out_valid, o_out_data, o_parity_err} !== {1'b1, 4'b1011, 1'b0}) begin
            bad++;
            $display("FAIL par good got=%b exp=%b",
                     {o_out_valid, o_out_data, o_parity_err}, {1'b1, 4'b1011, 1'b0});
        end
        tick();
        v = 5'b10110;
        start_frame();
        for (int i = 4; i >= 0; i--) begin
            i_ser_valid = 1'b1;
            i_ser_in    = v[i];
            tick();
        end
        i_ser_valid = 1'b0;
        total++;
        if ({o_out_valid, o_out_data, o_parity_err} !== {1'b1, 4'b1011, 1'b1}) begin
            bad++;
            $display("FAIL par bad got=%b exp=%b",
                     {o_out_valid, o_out_data, o_parity_err}, {1'b1, 4'b1011, 1'b1});
        end
        i_clr_ovr = 1'b1;
        tick();
        i_clr_ovr = 1'b0;
        total++;
        if (o_parity_err !== 1'b0) begin
            bad++;
            $display("FAIL par clear got=%b exp=0", o_parity_err);
        end
`else
        i_out_ready = 1'b1;
        start_frame();
        send_word(4'b1000, 1'b1);
        total++;
        if ({o_out_valid, o_out_data, o_parity_err} !== {1'b1, 4'b1000, 1'b0}) begin
            bad++;
            $display("FAIL par off got=%b exp=%b",
                     {o_out_valid, o_out_data, o_parity_err}, {1'b1, 4'b1000, 1'b0});
        end
        tick();
`endif
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        rst         = 1'b1;
        i_start     = 1'b0;
        i_ser_in    = 1'b0;
        i_ser_valid = 1'b0;
        i_out_ready = 1'b0;
        i_clr_ovr   = 1'b0;
        #1;
        test_reset();
        test_basic();
        test_gapped();
        test_overrun();
        test_back_to_back();
        test_restart();
        test_reset_mid();
        test_parity();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sipo_frame_ctrl.md
Name: sipo_frame_ctrl

Overview:
- Sequencing controller for a serial-in/parallel-out capture path.
- Frames a qualified serial bit stream into W-bit words:
  - gates shifting with ser_valid;
  - counts bits;
  - transfers each completed word to an output holding register;
  - presents the word on a valid/ready handshake.
- Sits between a serial front end (bit strobes plus frame start) and a parallel consumer.
- Detects overrun when the consumer stalls.

Parameters:
- W, 4, data word width in bits (≥2); bit counter width is clog2(W+1).

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high; clock clk
- start  input  1  frame start pulse, one cycle
- ser_in  input  1  serial data bit
- ser_valid  input  1  ser_in qualifier; one bit consumed per cycle it is high in SHIFT
- out_data  output  W  parallel word held for consumer
- out_valid  output  1  out_data valid
- out_ready  input  1  consumer accepts when out_valid & out_ready at a clock edge
- busy  output  1  high while in SHIFT (or PARITY)
- overrun  output  1  sticky: completed word dropped
- clr_ovr  input  1  synchronous clear of overrun
- parity_err  output  1  sticky parity error; constant 0 without the optional feature

Behaviour:
- Reset (async, rst=1) values:
  - state = IDLE; shift register = 0; bit count = 0;
  - out_data = 0; out_valid = 0; busy = 0; overrun = 0; parity_err = 0.
- States: IDLE, SHIFT (plus PARITY with the feature).
- IDLE:
  - start=1 → SHIFT, bit count cleared.
  - ser_valid is ignored in IDLE, including in the start cycle.
- SHIFT, each cycle with ser_valid=1:
  - shift register ← {shift[W-2:0], ser_in}, so the first bit received ends in the MSB;
  - bit count increments.
- SHIFT, ser_valid=0: hold; no timeout.
- Word completion, on the edge accepting bit W (count W-1 → W):
  - completed word = {shift[W-2:0], ser_in};
  - next state = IDLE, or PARITY with the feature.
- Word transfer:
  - If the output register is free (out_valid=0), or being emptied on this edge (out_valid & out_ready): out_data ← completed word; out_valid=1 from the next cycle.
  - Latency: out_valid rises one cycle after the edge that accepted the last bit.
  - If out_valid=1 & out_ready=0: the word is discarded, out_data is unchanged, and overrun ← 1.
- Handshake:
  - out_data is stable while out_valid & !out_ready.
  - out_valid clears on the accepting edge, unless a new word loads on that same edge; then out_valid stays 1 with the new data.
- Start while busy:
  - start=1 in SHIFT (or PARITY) restarts the frame: bit count ← 0 and the partial word is discarded.
  - No error flag is raised; a bit with ser_valid in the same cycle is not consumed.
- Overrun / clear:
  - overrun clears only via clr_ovr or rst.
  - clr_ovr and a new overrun on the same edge → overrun = 1 (set wins).
- busy = 1 exactly while state ≠ IDLE.
- Reset mid-frame: all state returns to reset values immediately; a pending out_valid word is lost.

Optional Feature:
- Macro: SIPO_FRAME_PARITY_EN.
- Defined:
  - After bit W, the FSM enters PARITY and waits for one more ser_valid bit, which must give even parity over the W data bits plus the parity bit.
  - The word transfers to the output only on the parity bit's edge, so latency is measured from that edge, and the FSM then returns to IDLE.
  - On a mismatch, the word is still delivered and parity_err ← 1 (sticky, cleared by clr_ovr or rst).
  - start during PARITY restarts the frame as in SHIFT.
- Not defined:
  - No PARITY state; the word completes on bit W.
  - parity_err is tied to 0.

Test Plan:
- Reset/basic (W=4): start, then bits 1,0,1,1 with ser_valid=1 and out_ready=1 → out_data=4'b1011, out_valid high for exactly 1 cycle, one cycle after the 4th bit edge; busy drops at the same time.
- Gapped input: bits 0,1,1,0 with ser_valid low for 3 cycles between bits → out_data=4'b0110, and no shift occurs on idle cycles.
- Backpressure/overrun: out_ready=0, send word 4'b1100, then word 4'b0011 → out_data stays 4'b1100 and overrun=1. Raise out_ready → handshake completes. Pulse clr_ovr → overrun=0.
- Simultaneous accept/load: hold out_valid with 4'b1010 and assert out_ready on the same edge that the next word 4'b0101 completes → out_valid stays 1, out_data=4'b0101, overrun=0.
- Restart and reset mid-frame:
  - Send bits 1,1, then start, then 0,0,0,1 → out_data=4'b0001.
  - Separately, assert rst after 2 bits → all outputs 0 immediately, FSM in IDLE.
- Parity (SIPO_FRAME_PARITY_EN defined):
  - Data 1,0,1,1 with parity 1 → out_data=4'b1011, parity_err=0.
  - Same data with parity 0 → word still delivered, parity_err=1.
